l1_bus_arbiter: RTL and testbench
=================================

Name: l1_bus_arbiter

Overview:
Round-robin arbiter and sequencer for the shared L1 cache bus unit (cache_bus_unit) request interface. It accepts up to NREQ cache-side requesters: L1-I, L1-D and the page-table walker by default. It grants one requester at a time, latches its command, and drives the single downstream request strobe set. Responses are steered back to the granted requester, and a watchdog aborts transactions the bus unit never completes.

Parameters:
NREQ, 3, number of requesters; index 0 = L1-D, 1 = PTW, 2 = L1-I
TIMEOUT, 1024, BUSY cycles without trans_rdy/bus_error before abort (>=2)
TW, 11, width of the watchdog counter (2^TW > TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request level, held until that requester's rsp_done
req_type  in  2*NREQ  per requester: 00 read_line, 01 read single, 10 write_through, 11 write_line
req_size  in  4*NREQ  per requester size, one-hot 0001/0010/0100/1000
req_pa  in  64*NREQ  per requester physical address
req_wdata  in  64*NREQ  per requester write-through data
arb_hold  in  1  blocks new grants; a transaction in flight completes normally
grant  out  NREQ  one-hot owner of the bus unit, 0 when idle
rsp_done  out  NREQ  one-cycle completion pulse to owner
rsp_err  out  NREQ  one-cycle error pulse to owner (bus_error or timeout)
rsp_line_write  out  NREQ  trans line_write steered to owner
rsp_entry_write  out  NREQ  cache_entry_write steered to owner
read_line_req  out  1  downstream strobe
read_req  out  1  downstream strobe
write_through_req  out  1  downstream strobe
write_line_req  out  1  downstream strobe
size  out  4  latched size
pa  out  64  latched address
wt_data  out  64  latched write data
trans_rdy  in  1  bus unit transfer complete
bus_error  in  1  bus unit access fault
line_write  in  1  bus unit cache line write strobe
cache_entry_write  in  1  bus unit entry refill strobe
timeout_flag  out  1  sticky; set on any watchdog abort, cleared only by rst
idle  out  1  high in IDLE state

Behaviour:
- Reset: state IDLE, grant=0, all strobes/rsp_* = 0, size/pa/wt_data = 0, rr pointer = 0 (next search starts at index 0), counter = 0, timeout_flag = 0, idle = 1.
- States: IDLE, BUSY, RELEASE.
- IDLE, when arb_hold = 0 and any req_valid is set:
  - Choose the first valid index searching cyclically from rr pointer.
  - Register grant, type, size, pa and wdata.
  - Set rr pointer = winner+1 mod NREQ.
  - Go to BUSY.
  - Downstream strobe rises the cycle after req_valid is sampled (1-cycle latency).
- BUSY:
  - Exactly one strobe, decoded from the latched type, is held high; size/pa/wt_data are stable.
  - line_write and cache_entry_write are ANDed with grant onto rsp_line_write/rsp_entry_write combinationally, with no added latency.
  - Counter increments each cycle.
- BUSY exit on trans_rdy=1: rsp_done[owner] pulses combinationally in that cycle; go to RELEASE.
- BUSY exit on bus_error=1: rsp_err[owner] pulses; rsp_done stays 0; go to RELEASE. If trans_rdy and bus_error are both high, bus_error wins.
- BUSY exit on counter == TIMEOUT-1 with no response: rsp_err[owner] pulses, timeout_flag sets, go to RELEASE.
- RELEASE (exactly 1 cycle):
  - All strobes low, grant cleared, counter cleared, go to IDLE.
  - Guarantees a strobe-low cycle between back-to-back transactions so the bus unit returns to idle.
  - trans_rdy or bus_error arriving in RELEASE/IDLE is ignored; no pulse is generated.
- Back-to-back throughput: at most one transaction per (service + 2) cycles.
- A requester dropping req_valid while granted does not cancel the transaction; it runs to completion.
- arb_hold rising during BUSY has no effect until the return to IDLE.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,2,0,…; no requester waits more than NREQ-1 transactions.
- grant is always one-hot or zero. rsp_done and rsp_err never go to a non-owner and are never both high.

Test Plan:
- Reset, then D-only read_line, pa=0x8000_0040, trans_rdy after 5 BUSY cycles -> read_line_req high cycles 2..6, pa=0x8000_0040, rsp_done[0] in the trans_rdy cycle, idle 2 cycles later.
- All three request continuously, each serviced in 3 cycles -> grant sequence 001,010,100,001; strobe low 1 cycle between transactions.
- PTW read, bus_error and trans_rdy asserted together -> rsp_err[1]=1, rsp_done=000, timeout_flag=0.
- TIMEOUT=8, I read_line, no response -> rsp_err[2] on 8th BUSY cycle, timeout_flag=1 and stays 1; a later trans_rdy during IDLE produces no pulse.
- arb_hold=1 with D waiting -> grant stays 0; arb_hold drops -> grant=001 next cycle. arb_hold raised during BUSY -> transaction completes.
- rst asserted mid-BUSY (write_line) -> next cycle all strobes 0, grant 0, idle=1, rr pointer 0.

Source files
------------

// File: rtl/l1_bus_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared L1 cache bus unit.
// One requester owns the bus unit per transaction; a watchdog aborts hung transfers.
module l1_bus_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_type,
    input  logic [4*NREQ-1:0]    req_size,
    input  logic [64*NREQ-1:0]   req_pa,
    input  logic [64*NREQ-1:0]   req_wdata,
    input  logic                 arb_hold,

    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      rsp_done,
    output logic [NREQ-1:0]      rsp_err,
    output logic [NREQ-1:0]      rsp_line_write,
    output logic [NREQ-1:0]      rsp_entry_write,

    output logic                 read_line_req,
    output logic                 read_req,
    output logic                 write_through_req,
    output logic                 write_line_req,
    output logic [3:0]           size,
    output logic [63:0]          pa,
    output logic [63:0]          wt_data,

    input  logic                 trans_rdy,
    input  logic                 bus_error,
    input  logic                 line_write,
    input  logic                 cache_entry_write,

    output logic                 timeout_flag,
    output logic                 idle
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_BUSY    = 2'b01,
        S_RELEASE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        T_READ_LINE     = 2'b00,
        T_READ          = 2'b01,
        T_WRITE_THROUGH = 2'b10,
        T_WRITE_LINE    = 2'b11
    } req_type_t;

    state_t        state;
    state_t        state_nxt;
    req_type_t     type_q;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] rr_nxt;
    logic          win_found;
    logic [TW-1:0] wd_cnt;

    logic          busy;
    logic          start;
    logic          hit_ok;
    logic          hit_err;
    logic          wd_expire;
    logic          finish;

    // Cyclic priority search: the first valid requester at or after rr_ptr wins.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand     = (int'(rr_ptr) + i) % NREQ;
            cand_idx = IW'(cand);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign rr_nxt = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    // bus_error outranks trans_rdy; the watchdog only fires when neither arrived.
    assign busy      = (state == S_BUSY);
    assign start     = (state == S_IDLE) && !arb_hold && win_found;
    assign hit_err   = busy && bus_error;
    assign hit_ok    = busy && trans_rdy && !bus_error;
    assign wd_expire = busy && !trans_rdy && !bus_error && (wd_cnt == TW'(TIMEOUT - 1));
    assign finish    = hit_ok || hit_err || wd_expire;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        idle              = 1'b0;
        read_line_req     = 1'b0;
        read_req          = 1'b0;
        write_through_req = 1'b0;
        write_line_req    = 1'b0;
        rsp_done          = '0;
        rsp_err           = '0;
        rsp_line_write    = grant & {NREQ{line_write}};
        rsp_entry_write   = grant & {NREQ{cache_entry_write}};

        case (state)
            S_IDLE: begin
                idle = 1'b1;
                if (start) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                case (type_q)
                    T_READ_LINE:     read_line_req     = 1'b1;
                    T_READ:          read_req          = 1'b1;
                    T_WRITE_THROUGH: write_through_req = 1'b1;
                    T_WRITE_LINE:    write_line_req    = 1'b1;
                    default:         read_line_req     = 1'b0;
                endcase
                rsp_done = grant & {NREQ{hit_ok}};
                rsp_err  = grant & {NREQ{hit_err || wd_expire}};
                if (finish) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch, owner register, round-robin pointer and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant        <= '0;
            type_q       <= T_READ_LINE;
            size         <= '0;
            pa           <= '0;
            wt_data      <= '0;
            rr_ptr       <= '0;
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (start) begin
                grant   <= NREQ'(1) << win_idx;
                type_q  <= req_type_t'(req_type[2*win_idx +: 2]);
                size    <= req_size[4*win_idx +: 4];
                pa      <= req_pa[64*win_idx +: 64];
                wt_data <= req_wdata[64*win_idx +: 64];
                rr_ptr  <= rr_nxt;
            end
            if (finish) begin
                grant <= '0;
            end
            if (busy) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (wd_expire) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    strobe_onehot_a: assert property (@(posedge clk) disable iff (rst)
        $onehot0({read_line_req, read_req, write_through_req, write_line_req}));
    rsp_exclusive_a: assert property (@(posedge clk) disable iff (rst)
        (rsp_done & rsp_err) == '0);

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Directed bench for l1_bus_arbiter: single transfers, rotation, error and
// watchdog aborts, arb_hold gating and mid-transfer reset.
module tb_l1_bus_arbiter;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 8;
    localparam int TW      = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_type;
    logic [4*NREQ-1:0] req_size;
    logic [64*NREQ-1:0] req_pa;
    logic [64*NREQ-1:0] req_wdata;
    logic              arb_hold;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   rsp_done;
    logic [NREQ-1:0]   rsp_err;
    logic [NREQ-1:0]   rsp_line_write;
    logic [NREQ-1:0]   rsp_entry_write;
    logic              read_line_req;
    logic              read_req;
    logic              write_through_req;
    logic              write_line_req;
    logic [3:0]        size;
    logic [63:0]       pa;
    logic [63:0]       wt_data;
    logic              trans_rdy;
    logic              bus_error;
    logic              line_write;
    logic              cache_entry_write;
    logic              timeout_flag;
    logic              idle;
    logic [3:0]        strobes;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign strobes = {read_line_req, read_req, write_through_req, write_line_req};

    l1_bus_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_type          (req_type),
        .req_size          (req_size),
        .req_pa            (req_pa),
        .req_wdata         (req_wdata),
        .arb_hold          (arb_hold),
        .grant             (grant),
        .rsp_done          (rsp_done),
        .rsp_err           (rsp_err),
        .rsp_line_write    (rsp_line_write),
        .rsp_entry_write   (rsp_entry_write),
        .read_line_req     (read_line_req),
        .read_req          (read_req),
        .write_through_req (write_through_req),
        .write_line_req    (write_line_req),
        .size              (size),
        .pa                (pa),
        .wt_data           (wt_data),
        .trans_rdy         (trans_rdy),
        .bus_error         (bus_error),
        .line_write        (line_write),
        .cache_entry_write (cache_entry_write),
        .timeout_flag      (timeout_flag),
        .idle              (idle)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Each cycle: inputs change 1 time unit after the edge, outputs are read 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] t, input logic [3:0] s,
                           input logic [63:0] a, input logic [63:0] d);
        req_type[2*i +: 2]   = t;
        req_size[4*i +: 4]   = s;
        req_pa[64*i +: 64]   = a;
        req_wdata[64*i +: 64] = d;
    endtask

    // Strobe vector order is {read_line, read, write_through, write_line}.
    function automatic logic [3:0] strobe_of(input logic [1:0] t);
        return 4'b1000 >> t;
    endfunction

    logic [1:0]  rot_type [NREQ];
    logic [63:0] rot_pa   [NREQ];
    logic [63:0] rot_data [NREQ];

    initial begin
        rst = 1'b1;
        req_valid = '0; req_type = '0; req_size = '0; req_pa = '0; req_wdata = '0;
        arb_hold = 1'b0; trans_rdy = 1'b0; bus_error = 1'b0;
        line_write = 1'b0; cache_entry_write = 1'b0;
        rot_type = '{2'b01, 2'b10, 2'b11};
        rot_pa   = '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_2008, 64'h0000_0000_0000_3040};
        rot_data = '{64'h1111_0000_0000_00d0, 64'h2222_0000_0000_00aa, 64'h3333_0000_0000_0055};

        // Reset state, then a single L1-D read_line answered after 5 BUSY cycles.
        do_reset();
        set_req(0, 2'b00, 4'b1000, 64'h0000_0000_8000_0040, 64'h0);
        req_valid = 3'b001;
        settle();
        check("rst_idle", idle, 1);
        check("rst_grant", grant, 0);
        check("rst_strobes", strobes, 0);
        check("rst_pa", pa, 0);
        check("rst_size", size, 0);
        check("rst_tflag", timeout_flag, 0);
        check("rst_rsp", {rsp_done, rsp_err}, 0);

        step(); settle();
        check("t1_c2_strobe", strobes, 4'b1000);
        check("t1_c2_grant", grant, 3'b001);
        check("t1_c2_pa", pa, 64'h0000_0000_8000_0040);
        check("t1_c2_size", size, 4'b1000);
        check("t1_c2_idle", idle, 0);
        step(); line_write = 1'b1; settle();
        check("t1_line_write", rsp_line_write, 3'b001);
        check("t1_c3_done", rsp_done, 0);
        step(); line_write = 1'b0; cache_entry_write = 1'b1; settle();
        check("t1_entry_write", rsp_entry_write, 3'b001);
        check("t1_c4_lw_off", rsp_line_write, 0);
        step(); cache_entry_write = 1'b0; settle();
        check("t1_c5_strobe", strobes, 4'b1000);
        step(); trans_rdy = 1'b1; settle();
        check("t1_c6_strobe", strobes, 4'b1000);
        check("t1_c6_done", rsp_done, 3'b001);
        check("t1_c6_err", rsp_err, 0);
        step(); trans_rdy = 1'b0; req_valid = '0; settle();
        check("t1_rel_strobe", strobes, 0);
        check("t1_rel_grant", grant, 0);
        check("t1_rel_idle", idle, 0);
        step(); settle();
        check("t1_c8_idle", idle, 1);

        // All three request continuously, each serviced in 3 BUSY cycles.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, rot_type[i], 4'b0001 << i, rot_pa[i], rot_data[i]);
        end
        req_valid = 3'b111;
        settle();
        for (int t = 0; t < 4; t++) begin
            int w;
            w = t % NREQ;
            step(); settle();
            check($sformatf("rot%0d_grant", t), grant, 64'(1) << w);
            check($sformatf("rot%0d_strobe", t), strobes, strobe_of(rot_type[w]));
            check($sformatf("rot%0d_pa", t), pa, rot_pa[w]);
            check($sformatf("rot%0d_wdata", t), wt_data, rot_data[w]);
            step(); settle();
            check($sformatf("rot%0d_b2_grant", t), grant, 64'(1) << w);
            step(); trans_rdy = 1'b1; settle();
            check($sformatf("rot%0d_done", t), rsp_done, 64'(1) << w);
            step(); trans_rdy = 1'b0;
            if (t == 3) req_valid = '0;
            settle();
            check($sformatf("rot%0d_rel_strobe", t), strobes, 0);
            check($sformatf("rot%0d_rel_grant", t), grant, 0);
            step(); settle();
            check($sformatf("rot%0d_idle", t), idle, 1);
        end

        // PTW read with bus_error and trans_rdy together: error wins.
        set_req(1, 2'b01, 4'b0001, 64'h0000_0000_0000_4000, 64'h0);
        req_valid = 3'b010;
        settle();
        step(); bus_error = 1'b1; trans_rdy = 1'b1; req_valid = '0; settle();
        check("t3_strobe", strobes, 4'b0100);
        check("t3_err", rsp_err, 3'b010);
        check("t3_done", rsp_done, 0);
        check("t3_tflag", timeout_flag, 0);
        step(); bus_error = 1'b0; trans_rdy = 1'b0; settle();
        check("t3_rel_err", rsp_err, 0);
        check("t3_rel_tflag", timeout_flag, 0);
        step(); settle();
        check("t3_idle", idle, 1);

        // L1-I read_line never answered: watchdog abort on the 8th BUSY cycle.
        set_req(2, 2'b00, 4'b0100, 64'h0000_0000_0000_5000, 64'h0);
        req_valid = 3'b100;
        settle();
        for (int k = 1; k <= TIMEOUT; k++) begin
            step();
            if (k == 2) req_valid = '0;
            settle();
            check($sformatf("t4_k%0d_err", k), rsp_err, (k == TIMEOUT) ? 3'b100 : 3'b000);
            check($sformatf("t4_k%0d_strobe", k), strobes, 4'b1000);
            check($sformatf("t4_k%0d_tflag", k), timeout_flag, 0);
        end
        step(); trans_rdy = 1'b1; settle();
        check("t4_rel_done", rsp_done, 0);
        check("t4_rel_err", rsp_err, 0);
        check("t4_rel_grant", grant, 0);
        check("t4_rel_tflag", timeout_flag, 1);
        step(); bus_error = 1'b1; settle();
        check("t4_idle_done", rsp_done, 0);
        check("t4_idle_err", rsp_err, 0);
        check("t4_idle_tflag", timeout_flag, 1);
        check("t4_idle", idle, 1);
        step(); trans_rdy = 1'b0; bus_error = 1'b0; settle();
        check("t4_still_idle", idle, 1);

        // arb_hold blocks a waiting L1-D; raising it during BUSY does not abort.
        arb_hold = 1'b1;
        set_req(0, 2'b01, 4'b0010, 64'h0000_0000_0000_6000, 64'h0);
        req_valid = 3'b001;
        settle();
        check("t5_hold_grant0", grant, 0);
        for (int i = 0; i < 3; i++) begin
            step(); settle();
            check($sformatf("t5_hold%0d_grant", i), grant, 0);
            check($sformatf("t5_hold%0d_idle", i), idle, 1);
        end
        step(); arb_hold = 1'b0; settle();
        check("t5_drop_grant", grant, 0);
        step(); arb_hold = 1'b1; settle();
        check("t5_grant", grant, 3'b001);
        step(); settle();
        check("t5_strobe", strobes, 4'b0100);
        step(); trans_rdy = 1'b1; settle();
        check("t5_done", rsp_done, 3'b001);
        step(); trans_rdy = 1'b0; req_valid = '0; arb_hold = 1'b0; settle();
        check("t5_rel_grant", grant, 0);
        step(); settle();
        check("t5_idle", idle, 1);

        // Reset during a write_line transfer; rr pointer must restart at 0.
        set_req(0, 2'b11, 4'b1000, 64'h0000_0000_0000_7000, 64'h0000_0000_dead_beef);
        req_valid = 3'b001;
        settle();
        step(); settle();
        check("t6_strobe", strobes, 4'b0001);
        check("t6_grant", grant, 3'b001);
        step(); rst = 1'b1; settle();
        check("t6_b2_strobe", strobes, 4'b0001);
        step(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, rot_type[i], 4'b0001 << i, rot_pa[i], rot_data[i]);
        end
        req_valid = 3'b111;
        settle();
        check("t6_rst_strobes", strobes, 0);
        check("t6_rst_grant", grant, 0);
        check("t6_rst_idle", idle, 1);
        check("t6_rst_pa", pa, 0);
        check("t6_rst_tflag", timeout_flag, 0);
        step(); settle();
        check("t6_rr_grant", grant, 3'b001);
        step(); trans_rdy = 1'b1; req_valid = '0; settle();
        check("t6_done", rsp_done, 3'b001);
        step(); trans_rdy = 1'b0; settle();
        step(); settle();
        check("t6_end_idle", idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
